// File: rtl/rx_frame_loader.sv
// rtl/rx_frame_loader.sv - 12-word receive frame loader with SOF resync and frame counter
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_sof/in_valid/in_ready
//                         64-bit word stream; in_sof marks word 0
//   x0..x4                IV, key hi/lo, nonce hi/lo (words 0-4)
//   d0..d2                associated data (words 5-7)
//   cyp0, cyp1            ciphertext (words 8-9)
//   tag0, tag1            received tag (words 10-11)
//   frame_valid/frame_ready
//                         complete frame held until accepted
//   sync_err              one-cycle pulse per framing error
//   frame_cnt             frames handed off since reset, wraps at 256

module rx_frame_loader (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_data,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] x0,
    output logic [63:0] x1,
    output logic [63:0] x2,
    output logic [63:0] x3,
    output logic [63:0] x4,
    output logic [63:0] d0,
    output logic [63:0] d1,
    output logic [63:0] d2,
    output logic [63:0] cyp0,
    output logic [63:0] cyp1,
    output logic [63:0] tag0,
    output logic [63:0] tag1,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        sync_err,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  idx;
    logic [63:0] field [12];
    logic        accept;

    assign in_ready    = (state == LOAD);
    assign frame_valid = (state == HOLD);
    assign accept      = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            idx       <= 4'd0;
            sync_err  <= 1'b0;
            frame_cnt <= 8'd0;
            for (int i = 0; i < 12; i++) begin
                field[i] <= 64'd0;
            end
        end else begin
            sync_err <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (in_sof) begin
                            // A start-of-frame always restarts; if a frame was
                            // in progress it is abandoned and flagged.
                            field[0] <= in_data;
                            idx      <= 4'd1;
                            sync_err <= (idx != 4'd0);
                        end else if (idx == 4'd0) begin
                            // Word arriving while waiting for SOF: drop it.
                            sync_err <= 1'b1;
                        end else begin
                            for (int i = 1; i < 12; i++) begin
                                if (idx == 4'(i)) begin
                                    field[i] <= in_data;
                                end
                            end
                            if (idx == 4'd11) begin
                                state <= HOLD;
                                idx   <= 4'd0;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        state     <= LOAD;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    assign x0   = field[0];
    assign x1   = field[1];
    assign x2   = field[2];
    assign x3   = field[3];
    assign x4   = field[4];
    assign d0   = field[5];
    assign d1   = field[6];
    assign d2   = field[7];
    assign cyp0 = field[8];
    assign cyp1 = field[9];
    assign tag0 = field[10];
    assign tag1 = field[11];

endmodule

// File: tb/tb_rx_frame_loader.sv
// tb/tb_rx_frame_loader.sv - self-checking bench for rx_frame_loader

module tb_rx_frame_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] x0, x1, x2, x3, x4, d0, d1, d2, cyp0, cyp1, tag0, tag1;
    logic        frame_valid;
    logic        frame_ready;
    logic        sync_err;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    rx_frame_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_sof      (in_sof),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .x0          (x0),
        .x1          (x1),
        .x2          (x2),
        .x3          (x3),
        .x4          (x4),
        .d0          (d0),
        .d1          (d1),
        .d2          (d2),
        .cyp0        (cyp0),
        .cyp1        (cyp1),
        .tag0        (tag0),
        .tag1        (tag1),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .sync_err    (sync_err),
        .frame_cnt   (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is a list of words; it is complete at 12.
    logic [63:0] m_part [$];
    logic [63:0] m_fields [12];
    logic        m_hold;
    logic        m_err;
    logic [7:0]  m_cnt;

    typedef struct {
        logic        v;
        logic        s;
        logic [63:0] d;
        logic        fr;
        logic        e_err;
        logic        e_rdy;
        logic        e_fv;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tq [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_part.delete();
        for (int i = 0; i < 12; i++) m_fields[i] = 64'd0;
        m_hold = 1'b0;
        m_err  = 1'b0;
        m_cnt  = 8'd0;
    endfunction

    function automatic void model_update(input logic v, input logic s,
                                         input logic [63:0] d, input logic fr);
        m_err = 1'b0;
        if (!m_hold) begin
            if (v) begin
                if (s) begin
                    if (m_part.size() != 0) m_err = 1'b1;
                    m_part.delete();
                    m_part.push_back(d);
                end else if (m_part.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    m_part.push_back(d);
                end
                if (m_part.size() == 12) begin
                    for (int i = 0; i < 12; i++) m_fields[i] = m_part[i];
                    m_part.delete();
                    m_hold = 1'b1;
                end
            end
        end else if (fr) begin
            m_hold = 1'b0;
            m_cnt  = m_cnt + 8'd1;
        end
    endfunction

    task automatic check_outputs(input logic fields_always);
        logic [63:0] got [12];
        got = '{x0, x1, x2, x3, x4, d0, d1, d2, cyp0, cyp1, tag0, tag1};
        chk("in_ready", {63'd0, in_ready}, {63'd0, !m_hold});
        chk("frame_valid", {63'd0, frame_valid}, {63'd0, m_hold});
        chk("sync_err", {63'd0, sync_err}, {63'd0, m_err});
        chk("frame_cnt", {56'd0, frame_cnt}, {56'd0, m_cnt});
        if (m_hold || fields_always) begin
            for (int i = 0; i < 12; i++) chk($sformatf("field%0d", i), got[i], m_fields[i]);
        end
    endtask

    task automatic step(input logic v, input logic s, input logic [63:0] d, input logic fr);
        in_valid    = v;
        in_sof      = s;
        in_data     = d;
        frame_ready = fr;
        model_update(v, s, d, fr);
        @(posedge clk);
        #1;
        check_outputs(1'b0);
    endtask

    // Reset asserted between edges, checked while held, released on a falling edge.
    task automatic apply_reset();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b1);
        in_valid    = 1'b0;
        in_sof      = 1'b0;
        frame_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] base, input logic fr);
        for (int i = 0; i < 12; i++) step(1'b1, i == 0, base + 64'(i), fr);
    endtask

    task automatic add(input logic v, input logic s, input logic [63:0] d, input logic fr,
                       input logic e_err, input logic e_rdy, input logic e_fv, input logic [7:0] e_cnt);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.fr = fr;
        t.e_err = e_err; t.e_rdy = e_rdy; t.e_fv = e_fv; t.e_cnt = e_cnt;
        tq.push_back(t);
    endtask

    initial begin
        logic [63:0] got [12];
        logic [63:0] held_x0;

        // Vector table: basic frame, idle errors, abandoned frame.
        for (int i = 0; i < 12; i++) add(1'b1, i == 0, 64'(i + 1), 1'b1, 1'b0, i != 11, i == 11, 8'd0);
        add(1'b1, 1'b0, 64'hDEAD, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 64'h50 + 64'(i), 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 5; i++) add(1'b1, i == 0, 64'h100 + 64'(i), 1'b1, 1'b0, 1'b1, 1'b0, 8'd1);
        add(1'b1, 1'b1, 64'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1);
        for (int i = 0; i < 11; i++) add(1'b1, 1'b0, 64'h200 + 64'(i), 1'b1, 1'b0, i != 10, i == 10, 8'd1);
        add(1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);

        rst_n = 1'b0;
        in_valid = 1'b0; in_sof = 1'b0; in_data = 64'd0; frame_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < tq.size(); k++) begin
            step(tq[k].v, tq[k].s, tq[k].d, tq[k].fr);
            chk($sformatf("tbl%0d_sync_err", k), {63'd0, sync_err}, {63'd0, tq[k].e_err});
            chk($sformatf("tbl%0d_in_ready", k), {63'd0, in_ready}, {63'd0, tq[k].e_rdy});
            chk($sformatf("tbl%0d_frame_valid", k), {63'd0, frame_valid}, {63'd0, tq[k].e_fv});
            chk($sformatf("tbl%0d_frame_cnt", k), {56'd0, frame_cnt}, {56'd0, tq[k].e_cnt});
            if (k == 11) begin
                got = '{x0, x1, x2, x3, x4, d0, d1, d2, cyp0, cyp1, tag0, tag1};
                for (int i = 0; i < 12; i++) chk($sformatf("basic_field%0d", i), got[i], 64'(i + 1));
            end
            if (k == 32) chk("resync_x0", x0, 64'hAA);
        end

        // Frame held with frame_ready low for 20 cycles, then released.
        send_frame(64'h300, 1'b0);
        held_x0 = x0;
        chk("hold_x0_loaded", held_x0, 64'h300);
        for (int i = 0; i < 20; i++) step(1'b1, i[0], 64'($urandom), 1'b0);
        chk("hold_x0_stable", x0, held_x0);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        chk("hold_release_fv", {63'd0, frame_valid}, 64'd0);

        // Reset during word 7 and during HOLD.
        for (int i = 0; i < 7; i++) step(1'b1, i == 0, 64'h400 + 64'(i), 1'b1);
        apply_reset();
        send_frame(64'h500, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0);
        apply_reset();
        send_frame(64'h600, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        chk("post_reset_cnt", {56'd0, frame_cnt}, 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            logic v, s;
            v = ($urandom_range(0, 9) < 7);
            s = (m_part.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 15) == 0);
            step(v, s, {$urandom, $urandom}, $urandom_range(0, 1) == 1);
        end

        // 257 handoffs from reset wrap the counter to 1.
        apply_reset();
        for (int f = 0; f < 257; f++) begin
            send_frame(64'(f) << 8, 1'b1);
            step(1'b0, 1'b0, 64'd0, 1'b1);
        end
        chk("wrap_cnt", {56'd0, frame_cnt}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
